// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: instruction field widths,
// opcode encodings and the NOP instruction word.
// Imported by the program memory and any decode logic.
package cpu_pkg;

  localparam int CPU_OPCODE_W  = 8;
  localparam int CPU_OPERAND_W = 16;
  localparam int CPU_WORD_W    = CPU_OPCODE_W + CPU_OPERAND_W;

  typedef enum logic [CPU_OPCODE_W-1:0] {
    OP_NOP = 8'h00,
    OP_LDI = 8'h01,
    OP_LD  = 8'h02,
    OP_ST  = 8'h03,
    OP_ADD = 8'h04,
    OP_INC = 8'h05,
    OP_JMP = 8'h06,
    OP_RST = 8'h07
  } opcode_e;

  // NOP opcode with a zero operand
  localparam logic [CPU_WORD_W-1:0] NOP_WORD = {OP_NOP, {CPU_OPERAND_W{1'b0}}};

endpackage

// File: rtl/prog_mem_array.sv
// Single-port synchronous RAM with a priority port mux: clear sweep, then program write, then fetch read.
// Latency: read data registered, valid one cycle after rd_en.
// Backpressure: none here; the caller guarantees only one port user wins per cycle.
module prog_mem_array #(
  parameter int                    WORD_WIDTH = 24,
  parameter int                    ADDR_BITS  = 4,
  parameter logic [WORD_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  clr_en,
  input  logic [ADDR_BITS-1:0]  clr_addr,
  input  logic                  prog_en,
  input  logic [ADDR_BITS-1:0]  prog_addr,
  input  logic [WORD_WIDTH-1:0] prog_data,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic                  we;
  logic                  re;
  logic [ADDR_BITS-1:0]  addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] rdata_d;
  logic [WORD_WIDTH-1:0] rdata_q;

  // Port arbitration: the sweep owns the port, then a program write, then a fetch read
  always_comb begin
    we    = 1'b0;
    re    = 1'b0;
    addr  = rd_addr;
    wdata = prog_data;
    if (clr_en) begin
      we    = 1'b1;
      addr  = clr_addr;
      wdata = FILL_WORD;
    end else if (prog_en) begin
      we    = 1'b1;
      addr  = prog_addr;
    end else if (rd_en) begin
      re    = 1'b1;
    end
    rdata_d = re ? mem[addr] : rdata_q;
  end

  // Storage and registered read port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Writable program memory: NOP sweep after reset, run-time programming port, registered fetch port.
// Latency: fetch_valid exactly one cycle after an accepted fetch_req.
// Backpressure: fetch_ready is low during the sweep and whenever prog_we is high; the CPU holds its request.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int WORD_WIDTH       = CPU_WORD_W,
  parameter int OPCODE_WIDTH     = CPU_OPCODE_W,
  parameter int ADDR_BITS        = 4,
  parameter int FETCH_ADDR_WIDTH = 16,
  parameter bit CLEAR_ON_RESET   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_req,
  input  logic [FETCH_ADDR_WIDTH-1:0] fetch_addr,
  output logic                        fetch_ready,
  output logic                        fetch_valid,
  output logic [WORD_WIDTH-1:0]       fetch_data,
  output logic                        fetch_fault,
  input  logic                        prog_we,
  input  logic [ADDR_BITS-1:0]        prog_addr,
  input  logic [WORD_WIDTH-1:0]       prog_data,
  output logic                        busy
);

  localparam logic [WORD_WIDTH-1:0] NOP_W =
    {OPCODE_WIDTH'(OP_NOP), {(WORD_WIDTH-OPCODE_WIDTH){1'b0}}};

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_cnt_q, clr_cnt_d;
  logic                  vld_q, vld_d;
  logic                  fault_q, fault_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic                  accept;
  logic                  in_range;
  logic                  run;
  logic [WORD_WIDTH-1:0] rdata;

  assign run         = (state_q == ST_RUN);
  assign busy        = (state_q == ST_CLEAR);
  assign fetch_ready = run && !prog_we;
  assign accept      = fetch_req && fetch_ready;
  // Any set bit above the array index means the PC points past the array; no wrapping
  assign in_range    = ((fetch_addr >> ADDR_BITS) == '0);

  // Sweep sequencing: walk clr_cnt over every word once, then hand over to RUN
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Response path: valid/fault track the accept, data holds the last delivered word
  always_comb begin
    vld_d       = accept;
    fault_d     = accept && !in_range;
    fetch_valid = vld_q;
    fetch_fault = vld_q && fault_q;
    fetch_data  = hold_q;
    if (vld_q) begin
      fetch_data = fault_q ? NOP_W : rdata;
    end
    hold_d      = fetch_data;
  end

  // State, sweep counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      vld_q     <= 1'b0;
      fault_q   <= 1'b0;
      hold_q    <= NOP_W;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      vld_q     <= vld_d;
      fault_q   <= fault_d;
      hold_q    <= hold_d;
    end
  end

  prog_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .FILL_WORD  (NOP_W)
  ) u_array (
    .clk       (clk),
    .clr_en    (busy),
    .clr_addr  (clr_cnt_q),
    .prog_en   (run && prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .rd_en     (accept && in_range),
    .rd_addr   (fetch_addr[ADDR_BITS-1:0]),
    .rdata     (rdata)
  );

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: reference model is a plain word array plus the expected response of the last cycle.
// Covers sweep length, programming, collisions, out-of-range faults, mid-run reset and the no-clear variant.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [23:0] fetch_data;
  logic        fetch_fault;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [23:0] prog_data;
  logic        busy;

  logic        b_rst_n;
  logic        b_fetch_req;
  logic [15:0] b_fetch_addr;
  logic        b_fetch_ready;
  logic        b_fetch_valid;
  logic [23:0] b_fetch_data;
  logic        b_fetch_fault;
  logic        b_prog_we;
  logic [3:0]  b_prog_addr;
  logic [23:0] b_prog_data;
  logic        b_busy;

  int checks   = 0;
  int failures = 0;

  logic [23:0] ref_mem [16];
  logic        exp_valid;
  logic        exp_fault;
  logic [23:0] exp_data;

  always #5 clk = ~clk;

  prog_mem u_dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
  );

  prog_mem #(.CLEAR_ON_RESET(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(b_rst_n),
    .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_ready(b_fetch_ready),
    .fetch_valid(b_fetch_valid), .fetch_data(b_fetch_data), .fetch_fault(b_fetch_fault),
    .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One RUN-state cycle: drive inputs, check ready, clock, check the response
  task automatic run_cycle(input bit we, input logic [3:0] wa, input logic [23:0] wd,
                           input bit req, input logic [15:0] fa, input string tag);
    logic        nv;
    logic        nf;
    logic [23:0] nd;
    prog_we = we; prog_addr = wa; prog_data = wd;
    fetch_req = req; fetch_addr = fa;
    #1;
    check_eq({tag, "_ready"}, 32'(fetch_ready), 32'(!we));
    nv = 1'b0; nf = 1'b0; nd = exp_data;
    if (we) begin
      ref_mem[wa] = wd;
    end else if (req) begin
      nv = 1'b1;
      if (fa < 16) nd = ref_mem[fa[3:0]];
      else begin nd = 24'h0; nf = 1'b1; end
    end
    @(posedge clk); #1;
    exp_valid = nv; exp_fault = nf; exp_data = nd;
    check_eq({tag, "_valid"}, 32'(fetch_valid), 32'(exp_valid));
    check_eq({tag, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
    check_eq({tag, "_data"},  32'(fetch_data),  32'(exp_data));
  endtask

  task automatic idle(input string tag);
    run_cycle(1'b0, 4'h0, 24'h0, 1'b0, 16'h0, tag);
  endtask

  // Count edges until busy drops, starting just after rst_n release
  task automatic measure_sweep(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      if (n == 2) check_eq({tag, "_ready_in_clear"}, 32'(fetch_ready), 32'h0);
      @(posedge clk); #1;
      n++;
      prog_we = 1'b0;
    end
    check_eq({tag, "_len"}, 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) ref_mem[i] = 24'h0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    b_rst_n = 1'b0; b_fetch_req = 1'b0; b_fetch_addr = '0;
    b_prog_we = 1'b0; b_prog_addr = '0; b_prog_data = '0;
    exp_valid = 1'b0; exp_fault = 1'b0; exp_data = 24'h0;
    #3;
    check_eq("rst_valid", 32'(fetch_valid), 32'h0);
    check_eq("rst_fault", 32'(fetch_fault), 32'h0);
    check_eq("rst_data",  32'(fetch_data),  32'h0);
    check_eq("rst_busy",  32'(busy),        32'h1);
    check_eq("rst_ready", 32'(fetch_ready), 32'h0);

    // Release reset; a write during the sweep must be dropped
    @(posedge clk); #1;
    rst_n = 1'b1;
    prog_we = 1'b1; prog_addr = 4'h5; prog_data = 24'hABCDEF;
    measure_sweep("sweep");

    for (int a = 0; a < 16; a++) run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'(a), "nop_fetch");
    idle("idle0");
    check_eq("hold_after_valid", 32'(fetch_data), 32'h0);

    // Program and fetch back-to-back
    run_cycle(1'b1, 4'd1,  24'h010005, 1'b0, 16'h0, "wr1");
    run_cycle(1'b1, 4'd10, 24'h060009, 1'b0, 16'h0, "wr10");
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'd1,  "fetch1");
    check_eq("ldi_word", 32'(fetch_data), 32'h010005);
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'd10, "fetch10");
    check_eq("jmp_word", 32'(fetch_data), 32'h060009);
    idle("idle1");

    // Write/fetch collision at address 3: request held, then accepted with new data
    run_cycle(1'b1, 4'd3, 24'h04_1234, 1'b1, 16'd3, "coll_wr");
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'd3, "coll_rd");
    check_eq("coll_word", 32'(fetch_data), 32'h041234);

    // Out of range: no wrap, NOP with fault, array untouched
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'h0010, "oor10");
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'hFFFF, "oorFF");
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'h0000, "after_oor0");
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'h0001, "after_oor1");
    idle("idle2");

    // Randomized traffic against the reference array
    for (int i = 0; i < 300; i++) begin
      bit          we  = ($urandom_range(0, 3) == 0);
      bit          req = ($urandom_range(0, 3) != 0);
      logic [15:0] fa  = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 15))
                                                     : 16'($urandom);
      run_cycle(we, 4'($urandom), 24'($urandom), req, fa, "rand");
    end
    for (int a = 0; a < 16; a++) run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'(a), "rand_dump");

    // Reset mid-run while a valid is out and another request is pending
    run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'd2, "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(fetch_valid), 32'h0);
    check_eq("midrst_fault", 32'(fetch_fault), 32'h0);
    check_eq("midrst_data",  32'(fetch_data),  32'h0);
    check_eq("midrst_busy",  32'(busy),        32'h1);
    @(posedge clk); #1;
    check_eq("midrst_valid2", 32'(fetch_valid), 32'h0);
    fetch_req = 1'b0;
    rst_n = 1'b1;
    exp_valid = 1'b0; exp_fault = 1'b0; exp_data = 24'h0;
    measure_sweep("resweep");
    for (int a = 0; a < 16; a++) run_cycle(1'b0, 4'h0, 24'h0, 1'b1, 16'(a), "resweep_fetch");
    idle("idle3");

    // No-clear variant: contents survive a reset pulse, no busy, ready at once
    begin
      logic [23:0] words [4];
      logic [3:0]  addrs [4];
      addrs[0] = 4'd2; addrs[1] = 4'd7; addrs[2] = 4'd11; addrs[3] = 4'd15;
      for (int i = 0; i < 4; i++) words[i] = 24'($urandom);
      @(posedge clk); #1;
      b_rst_n = 1'b1;
      #1;
      check_eq("nc_busy0", 32'(b_busy), 32'h0);
      for (int i = 0; i < 4; i++) begin
        b_prog_we = 1'b1; b_prog_addr = addrs[i]; b_prog_data = words[i];
        @(posedge clk); #1;
      end
      b_prog_we = 1'b0;
      @(negedge clk);
      b_rst_n = 1'b0;
      #1;
      check_eq("nc_rst_busy",  32'(b_busy),        32'h0);
      check_eq("nc_rst_valid", 32'(b_fetch_valid), 32'h0);
      check_eq("nc_rst_data",  32'(b_fetch_data),  32'h0);
      @(posedge clk); #1;
      b_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        b_fetch_req = 1'b1; b_fetch_addr = 16'(addrs[i]);
        #1;
        check_eq("nc_ready", 32'(b_fetch_ready), 32'h1);
        check_eq("nc_busy",  32'(b_busy),        32'h0);
        @(posedge clk); #1;
        check_eq("nc_valid", 32'(b_fetch_valid), 32'h1);
        check_eq("nc_fault", 32'(b_fetch_fault), 32'h0);
        check_eq("nc_data",  32'(b_fetch_data),  32'(words[i]));
      end
      b_fetch_req = 1'b0;
      @(posedge clk); #1;
      check_eq("nc_valid_drop", 32'(b_fetch_valid), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
